// File: rtl/fetch_unit_if.sv
// Bundle of the fetch stage's control inputs, instruction-memory port and
// IF/ID register outputs. The master side is the fetch unit itself.
interface fetch_unit_if;
  // Control from the rest of the core
  logic        start;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  // Instruction memory port (combinational read)
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  // IF/ID register and status
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc4;
  logic        halted;
  logic [31:0] fetch_count;
  // Current FSM state for observation (0 idle, 1 run, 2 halt)
  logic [1:0]  fsm_state;

  modport master (
    input  start, stall, redirect, redirect_pc, imem_instr,
    output imem_addr, ifid_valid, ifid_instr, ifid_pc, ifid_pc4,
           halted, fetch_count, fsm_state
  );

  modport slave (
    output start, stall, redirect, redirect_pc, imem_instr,
    input  imem_addr, ifid_valid, ifid_instr, ifid_pc, ifid_pc4,
           halted, fetch_count, fsm_state
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the PC, presents the word address to the
// instruction memory and captures instruction + PC into the IF/ID register.
// Handles start-up, stall, redirect (flush) and halt on EBREAK.
// Control is level-based: each rising edge applies redirect > stall > fetch;
// there is no valid/ready handshake -- stall is the only back-pressure and it
// freezes the PC and IF/ID contents for that edge.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] HALT_INSTR = 32'h0010_0073,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic         clock,
  input  logic         resetn,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q;
  logic        valid_q;
  logic [31:0] instr_q;
  logic [31:0] ifid_pc_q;
  logic [31:0] ifid_pc4_q;
  logic [31:0] count_q;

  logic        do_redirect;
  logic        do_fetch;
  logic        do_clear;
  logic        is_halt_instr;

  assign is_halt_instr = (bus.imem_instr == HALT_INSTR);

  // State register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and per-edge datapath action, redirect > stall > fetch
  always_comb begin
    state_d     = state_q;
    do_redirect = 1'b0;
    do_fetch    = 1'b0;
    do_clear    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) state_d = RUN;
      end
      RUN: begin
        if (bus.redirect) begin
          do_redirect = 1'b1;
        end else if (!bus.stall) begin
          do_fetch = 1'b1;
          if (is_halt_instr) state_d = HALT;
        end
      end
      HALT: begin
        // A redirect here means the EBREAK was on a wrong path
        if (bus.redirect) begin
          do_redirect = 1'b1;
          state_d     = RUN;
        end else if (!bus.stall) begin
          do_clear = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // PC, IF/ID register and saturating fetch counter
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pc_q       <= RESET_PC;
      valid_q    <= 1'b0;
      instr_q    <= NOP_INSTR;
      ifid_pc_q  <= 32'h0;
      ifid_pc4_q <= 32'h0;
      count_q    <= 32'h0;
    end else if (do_redirect) begin
      // Misaligned targets are silently word-aligned
      pc_q    <= {bus.redirect_pc[31:2], 2'b00};
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
    end else if (do_fetch) begin
      instr_q    <= bus.imem_instr;
      ifid_pc_q  <= pc_q;
      ifid_pc4_q <= pc_q + 32'd4;
      valid_q    <= 1'b1;
      if (count_q != 32'hFFFF_FFFF) count_q <= count_q + 32'd1;
      // EBREAK is latched but the PC stays on it while halted
      if (!is_halt_instr) pc_q <= pc_q + 32'd4;
    end else if (do_clear) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.imem_addr   = {2'b00, pc_q[31:2]};
  assign bus.ifid_valid  = valid_q;
  assign bus.ifid_instr  = instr_q;
  assign bus.ifid_pc     = ifid_pc_q;
  assign bus.ifid_pc4    = ifid_pc4_q;
  assign bus.halted      = (state_q == HALT);
  assign bus.fetch_count = count_q;
  assign bus.fsm_state   = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: start-up, stall, redirect, halt on EBREAK,
// PC wrap-around and asynchronous reset in the middle of a run.
module tb_fetch_unit;

  localparam logic [1:0]  S_IDLE = 2'd0;
  localparam logic [1:0]  S_RUN  = 2'd1;
  localparam logic [1:0]  S_HALT = 2'd2;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] EBRK   = 32'h0010_0073;
  localparam logic [31:0] I_ADD  = 32'h0020_81b3;
  localparam logic [31:0] I_SUB  = 32'h4020_81b3;
  localparam logic [31:0] I_OR   = 32'h0020_e1b3;
  localparam logic [31:0] I_3    = 32'h0030_0193;
  localparam logic [31:0] I_8    = 32'h0080_0313;
  localparam logic [31:0] I_16   = 32'h0400_0213;
  localparam logic [31:0] I_63   = 32'h3f00_0293;

  // ---------------- clock / reset ----------------
  logic clock;
  logic resetn;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  fetch_unit_if bus();

  fetch_unit dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus.master)
  );

  // ---------------- instruction memory model ----------------
  logic [31:0] imem [64];

  initial begin
    for (int i = 0; i < 64; i++) imem[i] = NOP;
    imem[0]  = I_ADD;
    imem[1]  = I_SUB;
    imem[2]  = I_OR;
    imem[3]  = I_3;
    imem[5]  = EBRK;
    imem[8]  = I_8;
    imem[16] = I_16;
    imem[63] = I_63;
  end

  assign bus.imem_instr = imem[bus.imem_addr[5:0]];

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [163:0] exp_q[$];
  logic [163:0] exp_v;
  logic [163:0] got_v;

  // Observed snapshot: state, halted, valid, imem_addr, ifid_pc, ifid_pc4, instr, count
  function automatic logic [163:0] snap();
    return {bus.fsm_state, bus.halted, bus.ifid_valid, bus.imem_addr,
            bus.ifid_pc, bus.ifid_pc4, bus.ifid_instr, bus.fetch_count};
  endfunction

  function automatic logic [163:0] mk(input logic [1:0] st, input logic h,
                                      input logic v, input logic [31:0] a,
                                      input logic [31:0] p, input logic [31:0] p4,
                                      input logic [31:0] ins, input logic [31:0] cnt);
    return {st, h, v, a, p, p4, ins, cnt};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic s, input logic st, input logic r, input logic [31:0] rpc);
    bus.start       = s;
    bus.stall       = st;
    bus.redirect    = r;
    bus.redirect_pc = rpc;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    resetn = 1'b0;
    #12;
    exp_v = mk(S_IDLE, 0, 0, 32'h0, 32'h0, 32'h0, NOP, 32'h0);
    got_v = snap();
    checks++;
    if (got_v !== exp_v) begin
      errors++; $display("FAIL reset_values got %h exp %h", got_v, exp_v);
    end
    @(negedge clock);
    resetn = 1'b1;
    // stall and redirect have no effect in IDLE
    drive(1'b0, 1'b1, 1'b1, 32'h40);
    step();
    step();
    got_v = snap();
    checks++;
    if (got_v !== exp_v) begin
      errors++; $display("FAIL idle_ignores_redirect got %h exp %h", got_v, exp_v);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_start_fetch(input string tag);
    exp_q.push_back(mk(S_RUN, 0, 0, 32'h0, 32'h0, 32'h0, NOP, 32'h0));
    exp_q.push_back(mk(S_RUN, 0, 1, 32'h1, 32'h0, 32'h4, I_ADD, 32'h1));
    exp_q.push_back(mk(S_RUN, 0, 1, 32'h2, 32'h4, 32'h8, I_SUB, 32'h2));
    exp_q.push_back(mk(S_RUN, 0, 1, 32'h3, 32'h8, 32'hC, I_OR, 32'h3));
    bus.start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      bus.start = 1'b0;
      exp_v = exp_q.pop_front();
      got_v = snap();
      checks++;
      if (got_v !== exp_v) begin
        errors++; $display("FAIL %s_edge%0d got %h exp %h", tag, i, got_v, exp_v);
      end
    end
  endtask

  task automatic test_stall();
    exp_v = mk(S_RUN, 0, 1, 32'h3, 32'h8, 32'hC, I_OR, 32'h3);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      got_v = snap();
      checks++;
      if (got_v !== exp_v) begin
        errors++; $display("FAIL stall_hold%0d got %h exp %h", i, got_v, exp_v);
      end
    end
    bus.stall = 1'b0;
    step();
    exp_v = mk(S_RUN, 0, 1, 32'h4, 32'hC, 32'h10, I_3, 32'h4);
    got_v = snap();
    checks++;
    if (got_v !== exp_v) begin
      errors++; $display("FAIL stall_release got %h exp %h", got_v, exp_v);
    end
  endtask

  task automatic test_redirect();
    // redirect wins over stall; misaligned target is word-aligned
    drive(1'b0, 1'b1, 1'b1, 32'h0000_0043);
    step();
    exp_v = mk(S_RUN, 0, 0, 32'h10, 32'hC, 32'h10, NOP, 32'h4);
    got_v = snap();
    checks++;
    if (got_v !== exp_v) begin
      errors++; $display("FAIL redirect_flush got %h exp %h", got_v, exp_v);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    exp_v = mk(S_RUN, 0, 1, 32'h11, 32'h40, 32'h44, I_16, 32'h5);
    got_v = snap();
    checks++;
    if (got_v !== exp_v) begin
      errors++; $display("FAIL redirect_target got %h exp %h", got_v, exp_v);
    end
  endtask

  task automatic test_halt();
    drive(1'b0, 1'b0, 1'b1, 32'h14);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    exp_v = mk(S_HALT, 1, 1, 32'h5, 32'h14, 32'h18, EBRK, 32'h6);
    got_v = snap();
    checks++;
    if (got_v !== exp_v) begin
      errors++; $display("FAIL halt_ebreak got %h exp %h", got_v, exp_v);
    end
    step();
    exp_v = mk(S_HALT, 1, 0, 32'h5, 32'h14, 32'h18, EBRK, 32'h6);
    got_v = snap();
    checks++;
    if (got_v !== exp_v) begin
      errors++; $display("FAIL halt_hold got %h exp %h", got_v, exp_v);
    end
    step();
    got_v = snap();
    checks++;
    if (got_v !== exp_v) begin
      errors++; $display("FAIL halt_stays got %h exp %h", got_v, exp_v);
    end
    drive(1'b0, 1'b0, 1'b1, 32'h0);
    step();
    exp_v = mk(S_RUN, 0, 0, 32'h0, 32'h14, 32'h18, NOP, 32'h6);
    got_v = snap();
    checks++;
    if (got_v !== exp_v) begin
      errors++; $display("FAIL halt_redirect got %h exp %h", got_v, exp_v);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    exp_v = mk(S_RUN, 0, 1, 32'h1, 32'h0, 32'h4, I_ADD, 32'h7);
    got_v = snap();
    checks++;
    if (got_v !== exp_v) begin
      errors++; $display("FAIL halt_refetch got %h exp %h", got_v, exp_v);
    end
  endtask

  task automatic test_wrap();
    drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    step();
    exp_v = mk(S_RUN, 0, 0, 32'h3FFF_FFFF, 32'h0, 32'h4, NOP, 32'h7);
    got_v = snap();
    checks++;
    if (got_v !== exp_v) begin
      errors++; $display("FAIL wrap_redirect got %h exp %h", got_v, exp_v);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    exp_v = mk(S_RUN, 0, 1, 32'h0, 32'hFFFF_FFFC, 32'h0, I_63, 32'h8);
    got_v = snap();
    checks++;
    if (got_v !== exp_v) begin
      errors++; $display("FAIL wrap_fetch got %h exp %h", got_v, exp_v);
    end
    step();
    exp_v = mk(S_RUN, 0, 1, 32'h1, 32'h0, 32'h4, I_ADD, 32'h9);
    got_v = snap();
    checks++;
    if (got_v !== exp_v) begin
      errors++; $display("FAIL wrap_next got %h exp %h", got_v, exp_v);
    end
  endtask

  task automatic test_reset_mid_run();
    drive(1'b0, 1'b0, 1'b1, 32'h20);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    exp_v = mk(S_RUN, 0, 1, 32'h9, 32'h20, 32'h24, I_8, 32'hA);
    got_v = snap();
    checks++;
    if (got_v !== exp_v) begin
      errors++; $display("FAIL pre_reset_state got %h exp %h", got_v, exp_v);
    end
    // assert reset between edges: outputs must clear without a clock edge
    #2;
    resetn = 1'b0;
    #1;
    exp_v = mk(S_IDLE, 0, 0, 32'h0, 32'h0, 32'h0, NOP, 32'h0);
    got_v = snap();
    checks++;
    if (got_v !== exp_v) begin
      errors++; $display("FAIL async_reset got %h exp %h", got_v, exp_v);
    end
    bus.start = 1'b1;
    step();
    got_v = snap();
    checks++;
    if (got_v !== exp_v) begin
      errors++; $display("FAIL start_in_reset got %h exp %h", got_v, exp_v);
    end
    bus.start = 1'b0;
    resetn    = 1'b1;
    step();
    got_v = snap();
    checks++;
    if (got_v !== exp_v) begin
      errors++; $display("FAIL idle_after_reset got %h exp %h", got_v, exp_v);
    end
    test_start_fetch("restart");
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    resetn = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    test_reset();
    test_start_fetch("start");
    test_stall();
    test_redirect();
    test_halt();
    test_wrap();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
